axi4lite_master_engine: RTL and testbench
=========================================

Name: axi4lite_master_engine

Overview:
Generic single-outstanding AXI4-Lite master. It converts a simple command/response interface into AXI4-Lite read or write transactions, and is the initiator counterpart to the team's AXI4-Lite register slaves (revision block, control blocks). Fabric logic uses it to read or write any slave register on the AXI interconnect.

Parameters:
AXI_ADDR_WIDTH, 32, width of cmd_addr and M_AXI_AWADDR/ARADDR
AXI_DATA_WIDTH, 32, width of data buses; WSTRB width = AXI_DATA_WIDTH/8

Ports:
AXI_ACLK  in  1  sole clock
AXI_ARESET  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  engine idle, accepts command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  AXI_ADDR_WIDTH  byte address
cmd_wdata  in  AXI_DATA_WIDTH  write data
cmd_wstrb  in  AXI_DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  user consumes response
rsp_rdata  out  AXI_DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP captured from slave
M_AXI_AWADDR  out  AXI_ADDR_WIDTH  write address
M_AXI_AWVALID  out  1
M_AXI_AWREADY  in  1
M_AXI_WDATA  out  AXI_DATA_WIDTH
M_AXI_WSTRB  out  AXI_DATA_WIDTH/8
M_AXI_WVALID  out  1
M_AXI_WREADY  in  1
M_AXI_BRESP  in  2
M_AXI_BVALID  in  1
M_AXI_BREADY  out  1
M_AXI_ARADDR  out  AXI_ADDR_WIDTH  read address
M_AXI_ARVALID  out  1
M_AXI_ARREADY  in  1
M_AXI_RDATA  in  AXI_DATA_WIDTH
M_AXI_RRESP  in  2
M_AXI_RVALID  in  1
M_AXI_RREADY  out  1

Behaviour:
- Reset (AXI_ARESET=1 at a clock edge): state=IDLE. All VALID/READY outputs 0, except cmd_ready=1. rsp_valid=0. All data/addr outputs 0. Reset mid-transaction aborts it immediately; no response is issued.
- All outputs are registered. Command is accepted on the cycle where cmd_valid & cmd_ready; addr, wdata, wstrb and write are latched then.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: cmd_ready=1. On accept: cmd_ready<=0. For a write, AWVALID<=1 and WVALID<=1 -> WR_ADDR_DATA. For a read, ARVALID<=1 -> RD_ADDR.
- WR_ADDR_DATA: AW and W complete independently. AWVALID drops the cycle after its handshake, WVALID likewise; the two may handshake in the same cycle or in either order. VALID is held stable until READY (no retraction, no data change). When both are done, BREADY<=1 -> WR_RESP.
- WR_RESP: on BVALID & BREADY: BREADY<=0, rsp_resp<=BRESP, rsp_rdata<=0, rsp_valid<=1 -> RESP.
- RD_ADDR: on ARVALID & ARREADY: ARVALID<=0, RREADY<=1 -> RD_DATA.
- RD_DATA: on RVALID & RREADY: RREADY<=0, rsp_rdata<=RDATA, rsp_resp<=RRESP, rsp_valid<=1 -> RESP.
- RESP: rsp_valid held with stable data until rsp_ready. On handshake: rsp_valid<=0, cmd_ready<=1 -> IDLE. Next command is accepted no earlier than the cycle after.
- Exactly one outstanding transaction. The engine never raises AW/W and AR together. SLVERR/DECERR are passed through unmodified and never stall the engine.
- Minimum latency with always-ready slave and user: write accept to rsp_valid = 3 cycles; read = 3 cycles.

Test Plan:
- Write 0x1234_5678, strb 0xF to 0x10 with slave ready immediately, BRESP=0 -> one AW/W beat carrying addr 0x10 and data 0x12345678; rsp_valid 3 cycles after accept, rsp_resp=0.
- Write with AWREADY delayed 4 cycles and WREADY immediate, then reversed order -> AWADDR and WDATA stay stable while VALID is high; exactly one handshake each; BREADY rises only after both complete.
- Read 0x04 where slave returns RDATA=0xDEADBEEF, RRESP=2 after a 5-cycle RVALID delay -> rsp_rdata=0xDEADBEEF, rsp_resp=2, engine returns to IDLE.
- rsp_ready held low 10 cycles while cmd_valid is asserted -> rsp fields stay stable; cmd_ready stays 0; new command is accepted only after the rsp handshake.
- Assert AXI_ARESET while in WR_ADDR_DATA -> next cycle all M_AXI VALID/READY outputs are 0, cmd_ready=1, rsp_valid=0.
- 100 back-to-back random reads and writes against a register-file slave model -> read-back data matches written data (per byte strobes); no overlapping AW/AR activity.

Source files
------------

// File: rtl/axi4lite_master_engine_if.sv
// Command/response and AXI4-Lite master signal bundle for axi4lite_master_engine.
// The master modport is the engine's view; slave is the environment's view.
interface axi4lite_master_engine_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
);
  localparam int unsigned StrbWidth = AXI_DATA_WIDTH / 8;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [AXI_ADDR_WIDTH-1:0] cmd_addr;
  logic [AXI_DATA_WIDTH-1:0] cmd_wdata;
  logic [StrbWidth-1:0]      cmd_wstrb;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]                rsp_resp;

  logic [AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic                      M_AXI_AWVALID;
  logic                      M_AXI_AWREADY;
  logic [AXI_DATA_WIDTH-1:0] M_AXI_WDATA;
  logic [StrbWidth-1:0]      M_AXI_WSTRB;
  logic                      M_AXI_WVALID;
  logic                      M_AXI_WREADY;
  logic [1:0]                M_AXI_BRESP;
  logic                      M_AXI_BVALID;
  logic                      M_AXI_BREADY;
  logic [AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic                      M_AXI_ARVALID;
  logic                      M_AXI_ARREADY;
  logic [AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]                M_AXI_RRESP;
  logic                      M_AXI_RVALID;
  logic                      M_AXI_RREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY
  );
endinterface

// File: rtl/axi4lite_master_engine.sv
// Single-outstanding AXI4-Lite master: turns one command into one read or write
// transaction and returns the slave's response. Every output is a register.
module axi4lite_master_engine #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
) (
  input  logic AXI_ACLK,
  input  logic AXI_ARESET,
  axi4lite_master_engine_if.master io_bus
);
  localparam int unsigned StrbWidth = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    StIdle,
    StWrAddrData,
    StWrResp,
    StRdAddr,
    StRdData,
    StResp
  } state_e;

  state_e                    r_state, w_state;
  logic                      r_cmd_ready, w_cmd_ready;
  logic                      r_awvalid, w_awvalid;
  logic                      r_wvalid, w_wvalid;
  logic                      r_bready, w_bready;
  logic                      r_arvalid, w_arvalid;
  logic                      r_rready, w_rready;
  logic                      r_rsp_valid, w_rsp_valid;
  logic [AXI_DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
  logic [1:0]                r_rsp_resp, w_rsp_resp;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr, w_awaddr;
  logic [AXI_DATA_WIDTH-1:0] r_wdata, w_wdata;
  logic [StrbWidth-1:0]      r_wstrb, w_wstrb;
  logic [AXI_ADDR_WIDTH-1:0] r_araddr, w_araddr;

  logic w_aw_hs, w_w_hs;

  assign w_aw_hs = r_awvalid & io_bus.M_AXI_AWREADY;
  assign w_w_hs  = r_wvalid & io_bus.M_AXI_WREADY;

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      r_state     <= StIdle;
      r_cmd_ready <= 1'b1;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_araddr    <= '0;
    end else begin
      r_state     <= w_state;
      r_cmd_ready <= w_cmd_ready;
      r_awvalid   <= w_awvalid;
      r_wvalid    <= w_wvalid;
      r_bready    <= w_bready;
      r_arvalid   <= w_arvalid;
      r_rready    <= w_rready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_resp  <= w_rsp_resp;
      r_awaddr    <= w_awaddr;
      r_wdata     <= w_wdata;
      r_wstrb     <= w_wstrb;
      r_araddr    <= w_araddr;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cmd_ready = r_cmd_ready;
    w_awvalid   = r_awvalid;
    w_wvalid    = r_wvalid;
    w_bready    = r_bready;
    w_arvalid   = r_arvalid;
    w_rready    = r_rready;
    w_rsp_valid = r_rsp_valid;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_resp  = r_rsp_resp;
    w_awaddr    = r_awaddr;
    w_wdata     = r_wdata;
    w_wstrb     = r_wstrb;
    w_araddr    = r_araddr;

    unique case (r_state)
      StIdle: begin
        if (io_bus.cmd_valid && r_cmd_ready) begin
          w_cmd_ready = 1'b0;
          if (io_bus.cmd_write) begin
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
            w_awaddr  = io_bus.cmd_addr;
            w_wdata   = io_bus.cmd_wdata;
            w_wstrb   = io_bus.cmd_wstrb;
            w_state   = StWrAddrData;
          end else begin
            w_arvalid = 1'b1;
            w_araddr  = io_bus.cmd_addr;
            w_state   = StRdAddr;
          end
        end
      end

      // AW and W retire independently; a dropped VALID marks that channel done.
      StWrAddrData: begin
        if (w_aw_hs) w_awvalid = 1'b0;
        if (w_w_hs) w_wvalid = 1'b0;
        if ((!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs)) begin
          w_bready = 1'b1;
          w_state  = StWrResp;
        end
      end

      StWrResp: begin
        if (r_bready && io_bus.M_AXI_BVALID) begin
          w_bready    = 1'b0;
          w_rsp_resp  = io_bus.M_AXI_BRESP;
          w_rsp_rdata = '0;
          w_rsp_valid = 1'b1;
          w_state     = StResp;
        end
      end

      StRdAddr: begin
        if (r_arvalid && io_bus.M_AXI_ARREADY) begin
          w_arvalid = 1'b0;
          w_rready  = 1'b1;
          w_state   = StRdData;
        end
      end

      StRdData: begin
        if (r_rready && io_bus.M_AXI_RVALID) begin
          w_rready    = 1'b0;
          w_rsp_rdata = io_bus.M_AXI_RDATA;
          w_rsp_resp  = io_bus.M_AXI_RRESP;
          w_rsp_valid = 1'b1;
          w_state     = StResp;
        end
      end

      StResp: begin
        if (r_rsp_valid && io_bus.rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_cmd_ready = 1'b1;
          w_state     = StIdle;
        end
      end

      default: w_state = StIdle;
    endcase
  end

  assign io_bus.cmd_ready     = r_cmd_ready;
  assign io_bus.rsp_valid     = r_rsp_valid;
  assign io_bus.rsp_rdata     = r_rsp_rdata;
  assign io_bus.rsp_resp      = r_rsp_resp;
  assign io_bus.M_AXI_AWADDR  = r_awaddr;
  assign io_bus.M_AXI_AWVALID = r_awvalid;
  assign io_bus.M_AXI_WDATA   = r_wdata;
  assign io_bus.M_AXI_WSTRB   = r_wstrb;
  assign io_bus.M_AXI_WVALID  = r_wvalid;
  assign io_bus.M_AXI_BREADY  = r_bready;
  assign io_bus.M_AXI_ARADDR  = r_araddr;
  assign io_bus.M_AXI_ARVALID = r_arvalid;
  assign io_bus.M_AXI_RREADY  = r_rready;
endmodule

// File: tb/tb_axi4lite_master_engine.sv
// Bench for axi4lite_master_engine: directed vector table, hand-written corner
// sequences and a random register-file run against a delay-configurable slave.
module tb_axi4lite_master_engine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4lite_master_engine_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) bus ();

  axi4lite_master_engine #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
    .AXI_ACLK  (clk),
    .AXI_ARESET(rst),
    .io_bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave configuration, written only by the main sequence.
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  resp_cfg = 2'd0;
  logic        rd_ovr = 1'b0;
  logic [31:0] rd_ovr_data = 32'h0;

  // Slave-side observations, written only by the slave process.
  logic [31:0] mem [16];
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  int          viol_overlap = 0, viol_stab = 0, viol_bready = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  logic [3:0]  last_wstrb = '0;

  // Register-file slave; acts 2 time units after each rising edge.
  initial begin
    logic aw_got, w_got, b_pend, r_pend;
    int aw_c, w_c, b_c, ar_c, r_c;
    logic [3:0] widx, ridx, ws;
    logic [31:0] wd;
    logic p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr, p_rst;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0] p_wstrb;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    widx = 0; ridx = 0; ws = 0; wd = 0;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_bv = 0; p_br = 0;
    p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0; p_rst = 1;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
    bus.M_AXI_BRESP = 0; bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0;
    bus.M_AXI_RDATA = 0; bus.M_AXI_RRESP = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
        bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0; bus.M_AXI_RDATA = 0;
      end else begin
        if (!p_rst) begin
          if (p_awv && p_awr) begin
            aw_got = 1; n_aw++; last_awaddr = p_awaddr; widx = p_awaddr[5:2];
            bus.M_AXI_AWREADY = 0; aw_c = 0;
          end
          if (p_wv && p_wr) begin
            w_got = 1; n_w++; wd = p_wdata; ws = p_wstrb;
            last_wdata = p_wdata; last_wstrb = p_wstrb;
            bus.M_AXI_WREADY = 0; w_c = 0;
          end
          if (p_bv && p_br) begin
            bus.M_AXI_BVALID = 0; b_pend = 0; aw_got = 0; w_got = 0; n_b++;
          end
          if (p_arv && p_arr) begin
            r_pend = 1; r_c = 0; ridx = p_araddr[5:2]; n_ar++; last_araddr = p_araddr;
            bus.M_AXI_ARREADY = 0; ar_c = 0;
          end
          if (p_rv && p_rr) begin
            bus.M_AXI_RVALID = 0; r_pend = 0; bus.M_AXI_RDATA = 0; n_r++;
          end
          // A VALID not yet accepted must stay up with unchanged payload.
          if (p_awv && !p_awr && (!bus.M_AXI_AWVALID || bus.M_AXI_AWADDR != p_awaddr))
            viol_stab++;
          if (p_wv && !p_wr && (!bus.M_AXI_WVALID || bus.M_AXI_WDATA != p_wdata ||
                                bus.M_AXI_WSTRB != p_wstrb))
            viol_stab++;
          if (p_arv && !p_arr && (!bus.M_AXI_ARVALID || bus.M_AXI_ARADDR != p_araddr))
            viol_stab++;
        end
        if (bus.M_AXI_AWVALID && !aw_got && !bus.M_AXI_AWREADY) begin
          if (aw_c >= aw_dly) bus.M_AXI_AWREADY = 1; else aw_c++;
        end
        if (bus.M_AXI_WVALID && !w_got && !bus.M_AXI_WREADY) begin
          if (w_c >= w_dly) bus.M_AXI_WREADY = 1; else w_c++;
        end
        if (aw_got && w_got && !b_pend) begin
          b_pend = 1; b_c = 0;
          for (int b = 0; b < 4; b++) if (ws[b]) mem[widx][8*b +: 8] = wd[8*b +: 8];
        end
        if (b_pend && !bus.M_AXI_BVALID) begin
          if (b_c >= b_dly) begin bus.M_AXI_BVALID = 1; bus.M_AXI_BRESP = resp_cfg; end
          else b_c++;
        end
        if (bus.M_AXI_ARVALID && !r_pend && !bus.M_AXI_ARREADY) begin
          if (ar_c >= ar_dly) bus.M_AXI_ARREADY = 1; else ar_c++;
        end
        if (r_pend && !bus.M_AXI_RVALID) begin
          if (r_c >= r_dly) begin
            bus.M_AXI_RVALID = 1;
            bus.M_AXI_RDATA  = rd_ovr ? rd_ovr_data : mem[ridx];
            bus.M_AXI_RRESP  = resp_cfg;
          end else r_c++;
        end
        if ((bus.M_AXI_ARVALID || bus.M_AXI_RREADY) &&
            (bus.M_AXI_AWVALID || bus.M_AXI_WVALID || bus.M_AXI_BREADY || aw_got || w_got))
          viol_overlap++;
        if (bus.M_AXI_BREADY && !(aw_got && w_got)) viol_bready++;
      end
      p_awv = bus.M_AXI_AWVALID; p_awr = bus.M_AXI_AWREADY; p_awaddr = bus.M_AXI_AWADDR;
      p_wv = bus.M_AXI_WVALID; p_wr = bus.M_AXI_WREADY;
      p_wdata = bus.M_AXI_WDATA; p_wstrb = bus.M_AXI_WSTRB;
      p_bv = bus.M_AXI_BVALID; p_br = bus.M_AXI_BREADY;
      p_arv = bus.M_AXI_ARVALID; p_arr = bus.M_AXI_ARREADY; p_araddr = bus.M_AXI_ARADDR;
      p_rv = bus.M_AXI_RVALID; p_rr = bus.M_AXI_RREADY;
      p_rst = rst;
    end
  end

  // One full command: offer, wait accept, count cycles to rsp_valid, consume.
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int hold, output logic [31:0] rdata,
                        output logic [1:0] resp, output int lat);
    int t;
    rdata = '0; resp = '0; lat = -1;
    @(negedge clk);
    bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = addr;
    bus.cmd_wdata = wdata; bus.cmd_wstrb = strb;
    t = 0;
    while (!bus.cmd_ready && t < 200) begin @(negedge clk); t++; end
    if (!bus.cmd_ready) begin
      check("cmd_accept_timeout", 0, 1);
      bus.cmd_valid = 0;
      return;
    end
    @(negedge clk);
    bus.cmd_valid = 0;
    lat = 1;
    while (!bus.rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!bus.rsp_valid) begin
      check("rsp_valid_timeout", 0, 1);
      return;
    end
    repeat (hold) @(negedge clk);
    rdata = bus.rsp_rdata; resp = bus.rsp_resp;
    bus.rsp_ready = 1;
    @(negedge clk);
    bus.rsp_ready = 0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  resp;
    logic        ovr;
    logic [31:0] ovr_data;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];
  logic [31:0] shadow [16];

  initial begin
    logic [31:0] rd, hold_rd;
    logic [1:0] rs, hold_rs;
    int lat, t, aw0, w0, ar0, exp_lat, hold;
    logic stable, busy_ok, wr, no_rsp;
    logic [3:0] strb, idx;
    logic [31:0] wdata;

    vecs[0]  = '{1'b1, 32'h10, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 2'd0, 1'b0, 32'h0,
                 32'h0, 2'd0, 3};
    vecs[1]  = '{1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd0, 1'b0, 32'h0,
                 32'h12345678, 2'd0, 3};
    vecs[2]  = '{1'b1, 32'h14, 32'hAABBCCDD, 4'h5, 4, 0, 0, 0, 0, 2'd0, 1'b0, 32'h0,
                 32'h0, 2'd0, 7};
    vecs[3]  = '{1'b1, 32'h18, 32'h11223344, 4'hA, 0, 4, 0, 0, 0, 2'd0, 1'b0, 32'h0,
                 32'h0, 2'd0, 7};
    vecs[4]  = '{1'b0, 32'h14, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd0, 1'b0, 32'h0,
                 32'h00BB00DD, 2'd0, 3};
    vecs[5]  = '{1'b0, 32'h18, 32'h0, 4'h0, 0, 0, 0, 2, 0, 2'd0, 1'b0, 32'h0,
                 32'h11003300, 2'd0, 5};
    vecs[6]  = '{1'b1, 32'h1C, 32'hCAFEF00D, 4'hF, 0, 0, 3, 0, 0, 2'd2, 1'b0, 32'h0,
                 32'h0, 2'd2, 6};
    vecs[7]  = '{1'b0, 32'h04, 32'h0, 4'h0, 0, 0, 0, 0, 5, 2'd2, 1'b1, 32'hDEADBEEF,
                 32'hDEADBEEF, 2'd2, 8};
    vecs[8]  = '{1'b0, 32'h1C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd3, 1'b0, 32'h0,
                 32'hCAFEF00D, 2'd3, 3};
    vecs[9]  = '{1'b1, 32'h10, 32'h000000FF, 4'h1, 0, 0, 0, 0, 0, 2'd0, 1'b0, 32'h0,
                 32'h0, 2'd0, 3};
    vecs[10] = '{1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd0, 1'b0, 32'h0,
                 32'h123456FF, 2'd0, 3};

    rst = 1;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
    bus.cmd_wstrb = 0; bus.rsp_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_valids", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}, 0);
    check("rst_readys", {bus.M_AXI_BREADY, bus.M_AXI_RREADY}, 0);
    check("rst_addr_data", {bus.M_AXI_AWADDR, bus.M_AXI_ARADDR}, 0);
    rst = 0;

    for (int i = 0; i < 11; i++) begin
      aw_dly = vecs[i].aw_d; w_dly = vecs[i].w_d; b_dly = vecs[i].b_d;
      ar_dly = vecs[i].ar_d; r_dly = vecs[i].r_d; resp_cfg = vecs[i].resp;
      rd_ovr = vecs[i].ovr; rd_ovr_data = vecs[i].ovr_data;
      aw0 = n_aw; w0 = n_w; ar0 = n_ar;
      do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 0, rd, rs, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_resp", i), rs, vecs[i].exp_resp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_aw_count", i), n_aw - aw0, vecs[i].wr ? 1 : 0);
      check($sformatf("vec%0d_w_count", i), n_w - w0, vecs[i].wr ? 1 : 0);
      check($sformatf("vec%0d_ar_count", i), n_ar - ar0, vecs[i].wr ? 0 : 1);
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_awaddr", i), last_awaddr, vecs[i].addr);
        check($sformatf("vec%0d_wdata", i), last_wdata, vecs[i].wdata);
        check($sformatf("vec%0d_wstrb", i), last_wstrb, vecs[i].strb);
      end else begin
        check($sformatf("vec%0d_araddr", i), last_araddr, vecs[i].addr);
      end
      check($sformatf("vec%0d_idle_after", i), {bus.cmd_ready, bus.rsp_valid}, 2'b10);
    end
    rd_ovr = 0; resp_cfg = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;

    // Response back-pressure with a second command already waiting.
    aw0 = n_aw;
    @(negedge clk);
    bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_addr = 32'h18;
    t = 0;
    while (!bus.cmd_ready && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    bus.cmd_write = 1; bus.cmd_addr = 32'h20; bus.cmd_wdata = 32'h5A5A5A5A; bus.cmd_wstrb = 4'hF;
    t = 0;
    while (!bus.rsp_valid && t < 200) begin @(negedge clk); t++; end
    hold_rd = bus.rsp_rdata; hold_rs = bus.rsp_resp;
    stable = 1; busy_ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== hold_rd || bus.rsp_resp !== hold_rs)
        stable = 0;
      if (bus.cmd_ready !== 1'b0) busy_ok = 0;
    end
    check("hold_rdata", hold_rd, 32'h11003300);
    check("hold_rsp_stable", stable, 1);
    check("hold_cmd_ready_low", busy_ok, 1);
    check("hold_no_early_aw", n_aw - aw0, 0);
    bus.rsp_ready = 1;
    @(negedge clk);
    bus.rsp_ready = 0;
    check("hold_release_state", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
    @(negedge clk);
    bus.cmd_valid = 0;
    check("hold_next_accepted", bus.cmd_ready, 0);
    t = 0;
    while (!bus.rsp_valid && t < 200) begin @(negedge clk); t++; end
    bus.rsp_ready = 1;
    @(negedge clk);
    bus.rsp_ready = 0;
    check("hold_next_aw_count", n_aw - aw0, 1);
    do_cmd(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, rs, lat);
    check("hold_next_readback", rd, 32'h5A5A5A5A);

    // Reset while both write channels are waiting on the slave.
    aw_dly = 10; w_dly = 10;
    aw0 = n_aw;
    @(negedge clk);
    bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 32'h24;
    bus.cmd_wdata = 32'h77777777; bus.cmd_wstrb = 4'hF;
    t = 0;
    while (!bus.cmd_ready && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    bus.cmd_valid = 0;
    @(negedge clk);
    check("abort_pre_valids", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID}, 2'b11);
    rst = 1;
    @(negedge clk);
    check("abort_valids", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}, 0);
    check("abort_readys", {bus.M_AXI_BREADY, bus.M_AXI_RREADY}, 0);
    check("abort_cmd_rsp", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
    check("abort_addr_data", {bus.M_AXI_AWADDR, bus.M_AXI_WDATA}, 0);
    rst = 0; aw_dly = 0; w_dly = 0;
    no_rsp = 1;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) no_rsp = 0;
    end
    check("abort_no_response", no_rsp, 1);
    check("abort_no_aw_hs", n_aw - aw0, 0);
    do_cmd(1'b0, 32'h24, 32'h0, 4'h0, 0, rd, rs, lat);
    check("abort_no_write_landed", rd, 32'h0);
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, rs, lat);
    check("abort_recover_read", rd, 32'h123456FF);

    // Random traffic against the register file, tracked by a shadow copy.
    for (int i = 0; i < 16; i++) begin
      wdata = $urandom;
      shadow[i] = wdata;
      do_cmd(1'b1, 32'(i * 4), wdata, 4'hF, 0, rd, rs, lat);
    end
    for (int i = 0; i < 100; i++) begin
      wr = 1'($urandom_range(0, 1));
      idx = 4'($urandom_range(0, 15));
      wdata = $urandom;
      strb = 4'($urandom_range(0, 15));
      aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2);
      b_dly = $urandom_range(0, 2); ar_dly = $urandom_range(0, 2);
      r_dly = $urandom_range(0, 2);
      hold = $urandom_range(0, 1);
      if (wr) exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
      else exp_lat = 3 + ar_dly + r_dly;
      do_cmd(wr, {26'h0, idx, 2'b00}, wdata, strb, hold, rd, rs, lat);
      check($sformatf("rand%0d_latency", i), lat, exp_lat);
      if (wr) begin
        for (int b = 0; b < 4; b++) if (strb[b]) shadow[idx][8*b +: 8] = wdata[8*b +: 8];
        check($sformatf("rand%0d_wr_rdata_zero", i), rd, 32'h0);
      end else begin
        check($sformatf("rand%0d_rdata", i), rd, shadow[idx]);
      end
    end

    check("no_aw_ar_overlap", viol_overlap, 0);
    check("valid_payload_stable", viol_stab, 0);
    check("bready_after_aw_and_w", viol_bready, 0);
    check("b_count_matches_aw", n_b, n_aw);
    check("r_count_matches_ar", n_r, n_ar);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
